// File: rtl/ifetch_resp_pkg.sv
// ifetch_resp_pkg: shared definitions for the instruction-fetch responder.
//   DEF_NOP_INST  - instruction returned on fault or when no valid data
//   LINE_OFS_W    - byte-offset width of one 64-bit line buffer entry
//   fetch_state_e - refill FSM state encoding
package ifetch_resp_pkg;

  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
  localparam int          LINE_OFS_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  // A fetch is misaligned when either of the two low address bits is set.
  function automatic logic is_misaligned(input logic [1:0] lo_bits);
    return (lo_bits != 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_line_buf.sv
// ifetch_line_buf: one-entry 64-bit instruction line buffer.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   invalidate    - clears the valid bit (takes priority over a fill)
//   fill_en       - write fill_tag/fill_data and mark the entry valid
//   fill_tag      - line tag of the refilled line
//   fill_data     - 64-bit refill data
//   lookup_tag    - tag of the current fetch address
//   lookup_hi     - selects the upper 32-bit half of the line
//   hit           - entry valid and tag matches
//   word          - selected 32-bit half of the stored line
module ifetch_line_buf
  import ifetch_resp_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         invalidate,
  input  logic                         fill_en,
  input  logic [ADDR_W-1:LINE_OFS_W]   fill_tag,
  input  logic [63:0]                  fill_data,
  input  logic [ADDR_W-1:LINE_OFS_W]   lookup_tag,
  input  logic                         lookup_hi,
  output logic                         hit,
  output logic [31:0]                  word
);

  logic                       buf_valid_r;
  logic [ADDR_W-1:LINE_OFS_W] buf_tag_r;
  logic [63:0]                buf_data_r;

  // Valid bit: invalidate wins over a simultaneous fill so fence.i is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_r <= 1'b0;
    end else if (invalidate) begin
      buf_valid_r <= 1'b0;
    end else if (fill_en) begin
      buf_valid_r <= 1'b1;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

  // Tag and data storage; contents are meaningless while buf_valid_r is low.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      buf_tag_r  <= fill_tag;
      buf_data_r <= fill_data;
    end else begin
      buf_tag_r  <= buf_tag_r;
      buf_data_r <= buf_data_r;
    end
  end

  // Hit compare and half-line select.
  always_comb begin
    hit  = buf_valid_r && (buf_tag_r == lookup_tag);
    word = 32'h0000_0000;
    if (lookup_hi) begin
      word = buf_data_r[63:32];
    end else begin
      word = buf_data_r[31:0];
    end
  end

endmodule

// File: rtl/ifetch_resp.sv
// ifetch_resp: instruction-side responder for the fetch stage.
// Returns a 32-bit instruction for inst_addr out of a one-entry line buffer,
// refilling it over a req/ack memory port on a miss.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   inst_addr/inst_ena- fetch request from the fetch stage
//   invalidate        - fence.i pulse, flushes the line buffer
//   inst/inst_valid   - returned instruction and its valid flag
//   inst_fault        - misaligned fetch
//   busy              - refill pending, fetch stage holds the PC
//   mem_req/mem_addr  - refill request (held until mem_ack) and line address
//   mem_ack/mem_rdata - refill data handshake
//   mem_err           - one-cycle pulse when a refill times out
module ifetch_resp
  import ifetch_resp_pkg::*;
#(
  parameter int          ADDR_W   = 64,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST,
  parameter int          TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_ena,
  input  logic              invalidate,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              inst_fault,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_rdata,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             poisoned_r;

  logic             hit_s;
  logic [31:0]      word_s;
  logic             start_fill_s;
  logic             fill_en_s;

  // A fill is kept only if no invalidate arrived during or with the ack.
  always_comb begin
    fill_en_s = (state_r == ST_REQ) && mem_ack && !poisoned_r && !invalidate;
  end

  ifetch_line_buf #(
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .invalidate (invalidate),
    .fill_en    (fill_en_s),
    .fill_tag   (mem_addr[ADDR_W-1:LINE_OFS_W]),
    .fill_data  (mem_rdata),
    .lookup_tag (inst_addr[ADDR_W-1:LINE_OFS_W]),
    .lookup_hi  (inst_addr[2]),
    .hit        (hit_s),
    .word       (word_s)
  );

  // Fetch-side response; data is only presented while no refill is in flight.
  always_comb begin
    inst_fault   = inst_ena && is_misaligned(inst_addr[1:0]);
    inst_valid   = inst_ena && !inst_fault && hit_s && (state_r == ST_IDLE);
    busy         = inst_ena && !inst_fault && !inst_valid;
    start_fill_s = inst_ena && !inst_fault && !hit_s;
    if (inst_valid) begin
      inst = word_s;
    end else begin
      inst = NOP_INST;
    end
  end

  // Refill FSM with wait counter and registered memory-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      poisoned_r <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_err    <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          poisoned_r <= 1'b0;
          if (start_fill_s) begin
            state_r  <= ST_REQ;
            mem_req  <= 1'b1;
            mem_addr <= {inst_addr[ADDR_W-1:LINE_OFS_W], {LINE_OFS_W{1'b0}}};
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        ST_REQ: begin
          if (invalidate) begin
            poisoned_r <= 1'b1;
          end
          if (mem_ack) begin
            state_r    <= ST_IDLE;
            mem_req    <= 1'b0;
            poisoned_r <= 1'b0;
          end else if (cnt_r == CNT_W'(TIMEOUT)) begin
            // Abandon; a persisting miss re-requests from IDLE next cycle.
            state_r    <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_err    <= 1'b1;
            poisoned_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          mem_req    <= 1'b0;
          poisoned_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
